stopwatch_counter_chain: RTL and testbench
==========================================

Name: stopwatch_counter_chain

Overview:
Parametrised MM:SS counter chain for the stopwatch datapath, running on a single system clock. It replaces gated 1 Hz/2 Hz clocking with internally generated single-cycle tick enables. It adds up/down counting, run/pause, field-local adjust, synchronous clear, and rollover/expiry pulses. Its BCD digit outputs feed the seven-segment display driver directly.

Parameters:
CLK_DIV_1HZ, 100000000, system clocks per 1 Hz tick; must be even and ≥ 2 (benches use 4)
MIN_TENS_MOD, 6, modulus of the minutes-tens digit (6 gives 00–59; legal range 1–10)
SEC_TENS_MOD, 6, modulus of the seconds-tens digit (legal range 1–10)
STOP_AT_ZERO, 1, 1: down-count holds at 00:00; 0: down-count wraps to the maximum value

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high; clears all state
run  in  1  level; 1 enables counting on each 1 Hz tick
adjust  in  1  level; 1 selects adjust mode, which overrides run
sel  in  1  adjust field select: 0 = seconds, 1 = minutes
dir  in  1  0 = count up, 1 = count down (applies in both count and adjust modes)
clear  in  1  synchronous clear to 00:00
min1  out  4  BCD minutes tens
min0  out  4  BCD minutes units
sec1  out  4  BCD seconds tens
sec0  out  4  BCD seconds units
tick_1hz  out  1  single-cycle 1 Hz enable pulse
tick_2hz  out  1  single-cycle 2 Hz enable pulse
rollover  out  1  single-cycle pulse when an up-count wraps from max to 00:00
expired  out  1  single-cycle pulse when a down-count reaches 00:00

Behaviour:
- Reset (asynchronous): all digits, prescaler, tick_1hz, tick_2hz, rollover and expired go to 0 immediately, without waiting for a clock edge.
- Prescaler: free-running counter p over 0..CLK_DIV_1HZ-1, wrapping to 0.
  - tick_2hz is registered and high for the cycle after p == CLK_DIV_1HZ/2-1 and for the cycle after p == CLK_DIV_1HZ-1.
  - tick_1hz is registered and high only for the cycle after p == CLK_DIV_1HZ-1.
  - clear resets p to 0.
- Digit update priority on each edge: clear, then adjust, then run, then hold.
- Tick use: the digit logic samples the registered tick outputs. Digits therefore change on the edge after a tick is seen high, and are always registered.
- clear=1: digits go to 00:00; rollover and expired stay 0 that cycle, even if a tick coincides.
- Count mode (adjust=0, run=1, tick_1hz=1):
  - dir=0: increment sec0 with ripple carry through sec1, min0, min1. Each units digit wraps 9→0. Each tens digit wraps at its own modulus minus 1.
  - dir=0 from the maximum value ((MIN_TENS_MOD-1)9:(SEC_TENS_MOD-1)9): go to 00:00 and pulse rollover in the same cycle the digits show 00:00.
  - dir=1: decrement with ripple borrow.
  - dir=1 from 00:01 (or any value reaching 00:00): pulse expired in the same cycle the digits show 00:00.
  - dir=1 at 00:00 with STOP_AT_ZERO=1: hold, no pulse.
  - dir=1 at 00:00 with STOP_AT_ZERO=0: wrap to the maximum value, no pulse.
- Adjust mode (adjust=1, tick_2hz=1):
  - The selected field steps by ±1 per dir, modulo 10·TENS_MOD of that field.
  - No carry or borrow into the other field; no rollover or expired pulses.
  - The unselected field holds. run is ignored.
- Hold: adjust=0 with run=0, or no relevant tick. Digits hold, but the prescaler keeps running.
- Changes to dir, sel or mode take effect on the next tick; a tick is never counted twice.
- Invariant: the digits are always valid BCD within their moduli; no illegal state is reachable.

Test Plan:
1. CLK_DIV_1HZ=4, run=1, dir=0, starting at 00:58 → 00:59, then 01:00 on successive tick_1hz. Separately, run from 59:59 → 00:00, with rollover high for exactly 1 cycle.
2. dir=1 starting at 01:00 → 00:59. Starting at 00:01 → 00:00 with a 1-cycle expired pulse. The next tick holds at 00:00 (STOP_AT_ZERO=1). With STOP_AT_ZERO=0, the next tick gives 59:59 and no pulse.
3. adjust=1, sel=1, dir=0 at 12:34, three tick_2hz → 15:34. Then sel=0 at 15:59, one tick → 15:00, minutes unchanged. dir=1 at 00:xx minutes → 59:xx.
4. Assert reset asynchronously mid-period at 07:42 → all outputs 0 before the next clock edge. After release, the first tick_1hz appears 4 cycles later and 2 tick_2hz occur per 4 cycles.
5. clear in the same cycle as a registered tick_1hz at 59:59 → 00:00 with no rollover. The prescaler restarts, and the next tick_1hz arrives CLK_DIV_1HZ cycles later.
6. run=0, adjust=0 across 3 tick_1hz periods at 03:21 → digits stay 03:21 and ticks continue. Set MIN_TENS_MOD=10 and count up from 99:59 → 00:00 with a rollover pulse.

Source files
------------

// File: rtl/stopwatch_counter_chain_if.sv
// Control and display bundle of the stopwatch MM:SS counter chain.
// The master drives the mode controls; the slave returns the BCD digits and the tick/event pulses.
interface stopwatch_counter_chain_if;
  logic       run;
  logic       adjust;
  logic       sel;
  logic       dir;
  logic       clear;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       rollover;
  logic       expired;

  modport master (
    output run, adjust, sel, dir, clear,
    input  min1, min0, sec1, sec0, tick_1hz, tick_2hz, rollover, expired
  );

  modport slave (
    input  run, adjust, sel, dir, clear,
    output min1, min0, sec1, sec0, tick_1hz, tick_2hz, rollover, expired
  );
endinterface

// File: rtl/stopwatch_counter_chain.sv
// Single-clock MM:SS BCD counter chain with internal 1 Hz / 2 Hz tick enables,
// up/down counting, run/pause, per-field adjust, synchronous clear and event pulses.
module stopwatch_counter_chain #(
  parameter int CLK_DIV_1HZ  = 100000000,
  parameter int MIN_TENS_MOD = 6,
  parameter int SEC_TENS_MOD = 6,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input logic                      clock,
  input logic                      reset,
  stopwatch_counter_chain_if.slave bus
);

  localparam int              PW      = $clog2(CLK_DIV_1HZ);
  localparam logic [PW-1:0]   P_HALF  = PW'(CLK_DIV_1HZ / 2 - 1);
  localparam logic [PW-1:0]   P_LAST  = PW'(CLK_DIV_1HZ - 1);
  localparam logic [3:0]      MIN_TOP = 4'(MIN_TENS_MOD - 1);
  localparam logic [3:0]      SEC_TOP = 4'(SEC_TENS_MOD - 1);

  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } mmss_t;

  // One digit stepped up or down inside 0..top; bit 4 flags the wrap (carry/borrow out).
  function automatic logic [4:0] step_digit(input logic [3:0] d, input logic [3:0] top,
                                            input logic down);
    if (down) return (d == 4'd0) ? {1'b1, top}  : {1'b0, d - 4'd1};
    else      return (d == top)  ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
  endfunction

  logic [PW-1:0] p;
  logic          tick_1hz, tick_2hz, rollover, expired;
  mmss_t         cur, nxt, count_next, adjust_next;
  logic [4:0]    s0, s1, m0, m1;
  logic          full_wrap, roll_next, exp_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    nxt         = cur;
    count_next  = cur;
    adjust_next = cur;
    roll_next   = 1'b0;
    exp_next    = 1'b0;

    s0 = step_digit(cur.sec0, 4'd9,    bus.dir);
    s1 = step_digit(cur.sec1, SEC_TOP, bus.dir);
    m0 = step_digit(cur.min0, 4'd9,    bus.dir);
    m1 = step_digit(cur.min1, MIN_TOP, bus.dir);

    // Ripple carry/borrow across all four digits for count mode.
    count_next.sec0 = s0[3:0];
    if (s0[4])                 count_next.sec1 = s1[3:0];
    if (s0[4] & s1[4])         count_next.min0 = m0[3:0];
    if (s0[4] & s1[4] & m0[4]) count_next.min1 = m1[3:0];
    full_wrap = s0[4] & s1[4] & m0[4] & m1[4];

    // Adjust keeps the carry inside the selected field.
    if (bus.sel) begin
      adjust_next.min0 = m0[3:0];
      if (m0[4]) adjust_next.min1 = m1[3:0];
    end else begin
      adjust_next.sec0 = s0[3:0];
      if (s0[4]) adjust_next.sec1 = s1[3:0];
    end

    if (bus.clear) begin
      nxt = '0;
    end else if (bus.adjust) begin
      if (tick_2hz) nxt = adjust_next;
    end else if (bus.run && tick_1hz) begin
      if (!(bus.dir && (cur == '0) && STOP_AT_ZERO)) begin
        nxt       = count_next;
        roll_next = !bus.dir && full_wrap;
        exp_next  = bus.dir && (count_next == '0);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously on posedge reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p        <= '0;
      tick_1hz <= 1'b0;
      tick_2hz <= 1'b0;
      cur      <= '0;
      rollover <= 1'b0;
      expired  <= 1'b0;
    end else begin
      cur      <= nxt;
      rollover <= roll_next;
      expired  <= exp_next;
      if (bus.clear) begin
        p        <= '0;
        tick_1hz <= 1'b0;
        tick_2hz <= 1'b0;
      end else begin
        p        <= (p == P_LAST) ? '0 : p + PW'(1);
        tick_1hz <= (p == P_LAST);
        tick_2hz <= (p == P_LAST) || (p == P_HALF);
      end
    end
  end

  assign bus.min1     = cur.min1;
  assign bus.min0     = cur.min0;
  assign bus.sec1     = cur.sec1;
  assign bus.sec0     = cur.sec0;
  assign bus.tick_1hz = tick_1hz;
  assign bus.tick_2hz = tick_2hz;
  assign bus.rollover = rollover;
  assign bus.expired  = expired;

endmodule

// File: tb/tb_stopwatch_counter_chain.sv
// Directed bench for stopwatch_counter_chain: three instances (default, wrap-at-zero,
// 00-99 minutes) share one stimulus; a vector table plus hand sequences check them.
module tb_stopwatch_counter_chain;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0, adjust = 1'b0, sel = 1'b0, dir = 1'b0, clear = 1'b0;

  int errors   = 0;
  int checks   = 0;
  int roll_cnt = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  stopwatch_counter_chain_if bus_a ();
  stopwatch_counter_chain_if bus_b ();
  stopwatch_counter_chain_if bus_c ();

  assign bus_a.run = run;  assign bus_a.adjust = adjust;  assign bus_a.sel = sel;
  assign bus_a.dir = dir;  assign bus_a.clear  = clear;
  assign bus_b.run = run;  assign bus_b.adjust = adjust;  assign bus_b.sel = sel;
  assign bus_b.dir = dir;  assign bus_b.clear  = clear;
  assign bus_c.run = run;  assign bus_c.adjust = adjust;  assign bus_c.sel = sel;
  assign bus_c.dir = dir;  assign bus_c.clear  = clear;

  stopwatch_counter_chain #(.CLK_DIV_1HZ(4)) dut_a (
    .clock(clk), .reset(rst), .bus(bus_a.slave));
  stopwatch_counter_chain #(.CLK_DIV_1HZ(4), .STOP_AT_ZERO(1'b0)) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b.slave));
  stopwatch_counter_chain #(.CLK_DIV_1HZ(4), .MIN_TENS_MOD(10)) dut_c (
    .clock(clk), .reset(rst), .bus(bus_c.slave));

  logic [15:0] time_a, time_b, time_c;
  assign time_a = {bus_a.min1, bus_a.min0, bus_a.sec1, bus_a.sec0};
  assign time_b = {bus_b.min1, bus_b.min0, bus_b.sec1, bus_b.sec0};
  assign time_c = {bus_c.min1, bus_c.min0, bus_c.sec1, bus_c.sec0};

  typedef struct {
    string       name;
    int          mm, ss;
    logic        run, adjust, sel, dir, use_1hz;
    int          n;
    logic [15:0] expect_time;
    int          rolls, exps;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input int mm, input int ss,
                     input logic r, input logic a, input logic s, input logic d,
                     input logic u, input int n, input logic [15:0] e,
                     input int rolls, input int exps);
    vec_t v;
    v.name = name; v.mm = mm; v.ss = ss;
    v.run = r; v.adjust = a; v.sel = s; v.dir = d; v.use_1hz = u;
    v.n = n; v.expect_time = e; v.rolls = rolls; v.exps = exps;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts n visible ticks on dut_a; each is consumed by the edge that follows it.
  task automatic pulses(input bit use_1hz, input int n);
    int cnt = 0;
    int budget = 0;
    while (cnt < n) begin
      if (use_1hz ? bus_a.tick_1hz : bus_a.tick_2hz) cnt++;
      cyc();
      budget++;
      roll_cnt += int'(bus_a.rollover);
      exp_cnt  += int'(bus_a.expired);
      if (budget > 8 * n + 16) begin
        check("tick_timeout", 32'(cnt), 32'(n));
        return;
      end
    end
  endtask

  task automatic wait_tick1();
    int budget = 0;
    while (!bus_a.tick_1hz && budget < 16) begin
      cyc();
      budget++;
    end
    if (!bus_a.tick_1hz) check("tick1_timeout", 32'(bus_a.tick_1hz), 32'd1);
  endtask

  task automatic cycles_to_tick1(output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!bus_a.tick_1hz && k < 20);
  endtask

  task automatic set_time(input int mm, input int ss);
    clear = 1'b1; cyc(); clear = 1'b0;
    run = 1'b0; adjust = 1'b1; dir = 1'b0;
    sel = 1'b1; if (mm > 0) pulses(1'b0, mm);
    sel = 1'b0; if (ss > 0) pulses(1'b0, ss);
    adjust = 1'b0;
  endtask

  // All-max via one downward adjust step per field from 00:00.
  task automatic set_max();
    clear = 1'b1; cyc(); clear = 1'b0;
    run = 1'b0; adjust = 1'b1; dir = 1'b1;
    sel = 1'b1; pulses(1'b0, 1);
    sel = 1'b0; pulses(1'b0, 1);
    adjust = 1'b0; dir = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t1, t2;

    //   name               mm  ss  run adj sel dir 1hz n  expected   roll exp
    add("up_58",            0,  58, 1,  0,  0,  0,  1,  1, 16'h0059, 0,   0);
    add("up_min_carry",     0,  58, 1,  0,  0,  0,  1,  2, 16'h0100, 0,   0);
    add("up_09_09",         9,  9,  1,  0,  0,  0,  1,  1, 16'h0910, 0,   0);
    add("down_borrow",      1,  0,  1,  0,  0,  1,  1,  1, 16'h0059, 0,   0);
    add("down_10_00",       10, 0,  1,  0,  0,  1,  1,  1, 16'h0959, 0,   0);
    add("down_expire",      0,  1,  1,  0,  0,  1,  1,  1, 16'h0000, 0,   1);
    add("down_hold_zero",   0,  1,  1,  0,  0,  1,  1,  3, 16'h0000, 0,   1);
    add("adj_min_up3",      12, 34, 0,  1,  1,  0,  0,  3, 16'h1534, 0,   0);
    add("adj_sec_wrap",     15, 59, 0,  1,  0,  0,  0,  1, 16'h1500, 0,   0);
    add("adj_min_down",     0,  34, 0,  1,  1,  1,  0,  1, 16'h5934, 0,   0);
    add("adj_sec_down",     0,  0,  0,  1,  0,  1,  0,  1, 16'h0059, 0,   0);
    add("adj_ignores_run",  5,  5,  1,  1,  0,  0,  0,  2, 16'h0507, 0,   0);
    add("adj_down_no_exp",  0,  1,  0,  1,  0,  1,  0,  1, 16'h0000, 0,   0);
    add("adj_up_no_roll",   59, 59, 0,  1,  0,  0,  0,  1, 16'h5900, 0,   0);
    add("pause",            3,  21, 0,  0,  0,  0,  1,  3, 16'h0321, 0,   0);

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset_digits", 32'(time_a), 32'h0);
    check("reset_flags", 32'({bus_a.tick_1hz, bus_a.tick_2hz, bus_a.rollover, bus_a.expired}), 32'h0);
    cyc(); cyc();
    rst = 1'b0;

    foreach (vq[i]) begin
      set_time(vq[i].mm, vq[i].ss);
      run = vq[i].run; adjust = vq[i].adjust; sel = vq[i].sel; dir = vq[i].dir;
      roll_cnt = 0; exp_cnt = 0;
      pulses(vq[i].use_1hz, vq[i].n);
      run = 1'b0; adjust = 1'b0; dir = 1'b0;
      check({vq[i].name, "_time"}, 32'(time_a), 32'(vq[i].expect_time));
      check({vq[i].name, "_rollover"}, 32'(roll_cnt), 32'(vq[i].rolls));
      check({vq[i].name, "_expired"}, 32'(exp_cnt), 32'(vq[i].exps));
    end

    // Rollover from the maximum value, 59:59 and 99:59 (MIN_TENS_MOD=10).
    set_max();
    check("max_a", 32'(time_a), 32'h5959);
    check("max_c", 32'(time_c), 32'h9959);
    run = 1'b1; dir = 1'b0;
    wait_tick1();
    cyc();
    check("roll_time_a", 32'(time_a), 32'h0000);
    check("roll_pulse_a", 32'(bus_a.rollover), 32'd1);
    check("roll_time_c", 32'(time_c), 32'h0000);
    check("roll_pulse_c", 32'(bus_c.rollover), 32'd1);
    cyc();
    check("roll_width_a", 32'(bus_a.rollover), 32'd0);
    check("roll_width_c", 32'(bus_c.rollover), 32'd0);
    run = 1'b0;

    // Down-count through zero: dut_a holds, dut_b wraps without a pulse.
    set_time(0, 1);
    run = 1'b1; dir = 1'b1;
    wait_tick1();
    cyc();
    check("wrap_b_zero", 32'(time_b), 32'h0000);
    check("wrap_b_expired", 32'(bus_b.expired), 32'd1);
    wait_tick1();
    cyc();
    check("wrap_b_max", 32'(time_b), 32'h5959);
    check("wrap_b_no_pulse", 32'(bus_b.expired), 32'd0);
    check("hold_a_zero", 32'(time_a), 32'h0000);
    check("hold_a_no_pulse", 32'(bus_a.expired), 32'd0);
    run = 1'b0; dir = 1'b0;

    // Clear coinciding with a registered tick_1hz at 59:59.
    set_max();
    run = 1'b1;
    wait_tick1();
    clear = 1'b1;
    cyc();
    clear = 1'b0; run = 1'b0;
    check("clear_time", 32'(time_a), 32'h0000);
    check("clear_no_roll", 32'(bus_a.rollover), 32'd0);
    cycles_to_tick1(k);
    check("clear_tick_delay", 32'(k), 32'd4);

    // Asynchronous reset mid-period at 07:42, then tick spacing after release.
    set_time(7, 42);
    check("preset_0742", 32'(time_a), 32'h0742);
    cyc();
    #3 rst = 1'b1;
    #1;
    check("async_rst_digits", 32'(time_a), 32'h0);
    check("async_rst_flags", 32'({bus_a.tick_1hz, bus_a.tick_2hz, bus_a.rollover, bus_a.expired}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycles_to_tick1(k);
    check("rst_tick_delay", 32'(k), 32'd4);
    t1 = 0; t2 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      t1 += int'(bus_a.tick_1hz);
      t2 += int'(bus_a.tick_2hz);
    end
    check("tick1_per_4", 32'(t1), 32'd1);
    check("tick2_per_4", 32'(t2), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
